// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster types and default 640x480@60 timing constants
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Half-open window test: lo <= v < hi
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// rtl/vga_timing_gen_wrap_counter.sv - enabled modulo-MAX counter exposing its next value
// wrap flags the terminal count so the parent can chain a second counter off it.
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX = 800
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t count,
  output coord_t next,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(MAX - 1);

  assign wrap = (count == LAST);

  always_comb begin
    next = count;
    if (en) begin
      next = wrap ? '0 : count + 10'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else begin
      count <= next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - divide-by-2 pixel clock and raster counters with hs/vs/blank decode
// Decoded outputs are registered from the counters' next values so they line up with DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   vga_clk,
  output logic   pixel_en,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   sync,
  output logic   frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_ACTIVE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;
  coord_t x_next;
  coord_t y_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vga_clk <= 1'b0;
    end else begin
      vga_clk <= ~vga_clk;
    end
  end

  // Counters advance on the edge that takes vga_clk low, keeping them stable across its rising edge
  assign pixel_en = vga_clk;
  assign v_en     = pixel_en & h_wrap;
  assign sync     = 1'b0;

  wrap_counter #(.MAX(H_TOTAL)) u_h_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (pixel_en),
    .count (DrawX),
    .next  (x_next),
    .wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL)) u_v_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (v_en),
    .count (DrawY),
    .next  (y_next),
    .wrap  (v_wrap)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hs          <= ~in_window(x_next, HS_START, HS_END);
      vs          <= ~in_window(y_next, VS_START, VS_END);
      blank       <= (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
      frame_start <= v_en & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - three timing configurations checked every cycle against an arithmetic raster model
module tb_vga_timing_gen;

  typedef struct packed {
    logic       vga_clk;
    logic       pixel_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       fs;
  } obs_t;

  // Instance 0: defaults, 1: default H with short V, 2: tiny raster
  int HA[3] = '{640, 640, 8};
  int HF[3] = '{16, 16, 2};
  int HW[3] = '{96, 96, 2};
  int HB[3] = '{48, 48, 2};
  int VA[3] = '{480, 8, 4};
  int VF[3] = '{10, 1, 1};
  int VW[3] = '{2, 1, 1};
  int VB[3] = '{33, 1, 1};

  logic       clk = 1'b0;
  logic       rst [3];
  logic       vclk[3];
  logic       pen [3];
  logic [9:0] dx  [3];
  logic [9:0] dy  [3];
  logic       hs  [3];
  logic       vs  [3];
  logic       blk [3];
  logic       syn [3];
  logic       fs  [3];

  longint n[3];
  logic   started[3] = '{1'b0, 1'b0, 1'b0};
  int     vectors = 0;
  int     miscompares = 0;
  int     printed = 0;

  always #10 clk = ~clk;

  vga_timing_gen u_dut_def (
    .Clk(clk), .Reset(rst[0]), .vga_clk(vclk[0]), .pixel_en(pen[0]), .DrawX(dx[0]), .DrawY(dy[0]),
    .hs(hs[0]), .vs(vs[0]), .blank(blk[0]), .sync(syn[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_dut_shortv (
    .Clk(clk), .Reset(rst[1]), .vga_clk(vclk[1]), .pixel_en(pen[1]), .DrawX(dx[1]), .DrawY(dy[1]),
    .hs(hs[1]), .vs(vs[1]), .blank(blk[1]), .sync(syn[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_dut_small (
    .Clk(clk), .Reset(rst[2]), .vga_clk(vclk[2]), .pixel_en(pen[2]), .DrawX(dx[2]), .DrawY(dy[2]),
    .hs(hs[2]), .vs(vs[2]), .blank(blk[2]), .sync(syn[2]), .frame_start(fs[2])
  );

  // n = Clk edges since the last reset edge; everything else follows from it arithmetically
  function automatic obs_t model(int i, longint nn);
    obs_t   m;
    int     ht = HA[i] + HF[i] + HW[i] + HB[i];
    int     vt = VA[i] + VF[i] + VW[i] + VB[i];
    longint k  = nn / 2;
    int     x  = int'(k % ht);
    int     y  = int'((k / ht) % vt);
    m.vga_clk  = (nn % 2) == 1;
    m.pixel_en = (nn % 2) == 1;
    m.x        = 10'(x);
    m.y        = 10'(y);
    m.hs       = !(x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HW[i]);
    m.vs       = !(y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VW[i]);
    m.blank    = (x < HA[i]) && (y < VA[i]);
    m.sync     = 1'b0;
    m.fs       = ((nn % 2) == 0) && (k > 0) && ((k % (ht * vt)) == 0);
    return m;
  endfunction

  function automatic obs_t actual(int i);
    return '{vga_clk: vclk[i], pixel_en: pen[i], x: dx[i], y: dy[i], hs: hs[i],
             vs: vs[i], blank: blk[i], sync: syn[i], fs: fs[i]};
  endfunction

  task automatic chk(string name, longint got, longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        n[i]       <= 0;
        started[i] <= 1'b1;
      end else begin
        n[i] <= n[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (started[i]) begin
        obs_t got;
        obs_t exp;
        got = actual(i);
        exp = model(i, n[i]);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          if (printed < 20) begin
            printed++;
            $display("FAIL raster inst%0d n=%0d: got x=%0d y=%0d vclk=%b pen=%b hs=%b vs=%b blank=%b sync=%b fs=%b, expected x=%0d y=%0d vclk=%b pen=%b hs=%b vs=%b blank=%b sync=%b fs=%b",
                     i, n[i], got.x, got.y, got.vga_clk, got.pixel_en, got.hs, got.vs, got.blank, got.sync, got.fs,
                     exp.x, exp.y, exp.vga_clk, exp.pixel_en, exp.hs, exp.vs, exp.blank, exp.sync, exp.fs);
          end
        end
      end
    end
  end

  initial begin
    obs_t   rst_obs;
    obs_t   m;
    int     hs_cycles = 0;
    int     hs_min = 1023;
    int     hs_max = 0;
    int     b_fs = 0;
    longint c_fs[$];
    bit     found;

    rst_obs = '{vga_clk: 1'b0, pixel_en: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1,
                vs: 1'b1, blank: 1'b1, sync: 1'b0, fs: 1'b0};

    // Hand-computed points that pin the model
    m = model(0, 2 * 656);       chk("model_hs_656", m.hs, 0);
    m = model(0, 2 * 655 + 1);   chk("model_hs_655", m.hs, 1);
    m = model(0, 2 * 751 + 1);   chk("model_hs_751", m.hs, 0);
    m = model(0, 2 * 752);       chk("model_hs_752", m.hs, 1);
    m = model(0, 2 * 640);       chk("model_blank_640", m.blank, 0);
    m = model(0, 2 * 800 * 490); chk("model_vs_490", m.vs, 0);
    m = model(0, 2 * 800 * 492); chk("model_vs_492", m.vs, 1);
    m = model(2, 196);           chk("model_fs_196", m.fs, 1);
    m = model(2, 197);           chk("model_fs_197", m.fs, 0);
    m = model(1, 2 * 800 * 8);   chk("model_wrap_y", m.y, 8);

    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state%0d", i), actual(i), rst_obs);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    chk("vga_clk_first_edge", vclk[0], 1);
    chk("pixel_en_first_edge", pen[0], 1);

    for (int c = 2; c < 21000; c++) begin
      @(negedge clk);
      if (dy[0] == 10'd0 && hs[0] == 1'b0) begin
        hs_cycles++;
        if (int'(dx[0]) < hs_min) hs_min = int'(dx[0]);
        if (int'(dx[0]) > hs_max) hs_max = int'(dx[0]);
      end
      if (fs[1]) b_fs++;
      if (c < 500) begin
        if (fs[2]) c_fs.push_back(longint'(c));
      end else begin
        rst[2] = ($urandom_range(0, 199) == 0);
      end
    end
    rst[2] = 1'b0;

    chk("hs_low_clks_line0", hs_cycles, 192);
    chk("hs_first_x", hs_min, 656);
    chk("hs_last_x", hs_max, 751);
    chk("shortv_frame_starts", b_fs, 1);
    chk("small_fs_count", c_fs.size(), 2);
    if (c_fs.size() >= 2) begin
      chk("small_fs_first", c_fs[0], 196);
      chk("small_fs_period", c_fs[1] - c_fs[0], 196);
    end

    found = 1'b0;
    for (int c = 0; c < 40000 && !found; c++) begin
      @(negedge clk);
      if (dx[1] == 10'd300 && dy[1] == 10'd2 && vclk[1] == 1'b0) found = 1'b1;
    end
    chk("midframe_reached", found, 1);
    if (found) begin
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("midframe_reset_state", actual(1), rst_obs);
      @(negedge clk);
      chk("midframe_release_fs", fs[1], 0);
      chk("midframe_release_vclk", vclk[1], 1);
    end
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
